// File: rtl/clk_sched_pkg.sv
// Shared types and defaults for the run/pause/single-step slow-clock scheduler.
package clk_sched_pkg;

  localparam int unsigned RATE_SEL_W = 2;
  localparam int unsigned DEF_CNT_W  = 27;

  // Default half-periods in 100 MHz cycles: 500 Hz, 50 Hz, 5 Hz, 1 Hz.
  localparam int unsigned DEF_RATE0 = 100_000;
  localparam int unsigned DEF_RATE1 = 1_000_000;
  localparam int unsigned DEF_RATE2 = 10_000_000;
  localparam int unsigned DEF_RATE3 = 50_000_000;

  typedef enum logic [1:0] {
    StPause = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2
  } schedState_e;

  function automatic int unsigned rateHp(input logic [RATE_SEL_W-1:0] sel,
                                         input int unsigned r0, input int unsigned r1,
                                         input int unsigned r2, input int unsigned r3);
    unique case (sel)
      2'd0:    return r0;
      2'd1:    return r1;
      2'd2:    return r2;
      default: return r3;
    endcase
  endfunction

endpackage

// File: rtl/clk_enable_scheduler_if.sv
// Control/status bundle between the board-side controls and the slow-clock scheduler.
interface clk_enable_scheduler_if
  import clk_sched_pkg::*;
();

  logic                  run;
  logic                  stepReq;
  logic [RATE_SEL_W-1:0] rateSel;
  logic                  rateLoad;
  logic                  rateAck;
  logic [RATE_SEL_W-1:0] curRate;
  logic                  slowClk;
  logic                  tickEn;
  logic                  busy;

  modport master (
    output run, stepReq, rateSel, rateLoad,
    input  rateAck, curRate, slowClk, tickEn, busy
  );

  modport slave (
    input  run, stepReq, rateSel, rateLoad,
    output rateAck, curRate, slowClk, tickEn, busy
  );

endinterface

// File: rtl/rise_detect.sv
// One-flop rising-edge detector for a synchronous level input.
module rise_detect (
  input  logic inClk,
  input  logic reset,
  input  logic sigIn,
  output logic rise
);

  logic prevQ;

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      prevQ <= 1'b0;
    end else begin
      prevQ <= sigIn;
    end
  end

  assign rise = sigIn & ~prevQ;

endmodule

// File: rtl/clk_enable_scheduler.sv
// Run/pause/single-step slow-clock generator with a selectable rate table; rate
// changes land only on period boundaries so slowClk never glitches.
module clk_enable_scheduler
  import clk_sched_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned RATE0      = DEF_RATE0,
  parameter int unsigned RATE1      = DEF_RATE1,
  parameter int unsigned RATE2      = DEF_RATE2,
  parameter int unsigned RATE3      = DEF_RATE3,
  parameter int unsigned RESET_RATE = 0
) (
  input logic                   inClk,
  input logic                   reset,
  clk_enable_scheduler_if.slave bus
);

  if ((RATE0 < 2) || (RATE1 < 2) || (RATE2 < 2) || (RATE3 < 2) || (RESET_RATE > 3)) begin : gBadCfg
    $error("clk_enable_scheduler: every RATE must be >= 2 and RESET_RATE must be 0..3");
  end

  schedState_e           state;
  logic [CNT_W-1:0]      cnt;
  logic                  starting;
  logic                  slowClkQ;
  logic                  tickEnQ;
  logic                  rateAckQ;
  logic [RATE_SEL_W-1:0] curRateQ;
  logic [RATE_SEL_W-1:0] pendRate;
  logic                  pendValid;
  logic                  stepRise;

  logic [CNT_W-1:0] hpLast;
  logic             wrap;
  logic             boundary;
  logic             applyRate;

  rise_detect uStepEdge (
    .inClk (inClk),
    .reset (reset),
    .sigIn (bus.stepReq),
    .rise  (stepRise)
  );

  assign hpLast = CNT_W'(rateHp(curRateQ, RATE0, RATE1, RATE2, RATE3) - 1);
  assign wrap   = (cnt == hpLast);

  // The entry cycle after leaving PAUSE is not a boundary; counting starts after it.
  assign boundary  = (state != StPause) && !starting && wrap && !slowClkQ;
  assign applyRate = pendValid && ((state == StPause) || boundary);

  always_ff @(posedge inClk or posedge reset) begin
    if (reset) begin
      state     <= StPause;
      cnt       <= '0;
      starting  <= 1'b0;
      slowClkQ  <= 1'b0;
      tickEnQ   <= 1'b0;
      rateAckQ  <= 1'b0;
      curRateQ  <= RATE_SEL_W'(RESET_RATE);
      pendRate  <= '0;
      pendValid <= 1'b0;
    end else begin
      tickEnQ  <= 1'b0;
      rateAckQ <= 1'b0;

      if (bus.rateLoad) begin
        pendRate  <= bus.rateSel;
        pendValid <= 1'b1;
      end
      // A load coinciding with an application stays pending for the next one.
      if (applyRate) begin
        curRateQ <= pendRate;
        rateAckQ <= 1'b1;
        if (!bus.rateLoad) begin
          pendValid <= 1'b0;
        end
      end

      unique case (state)
        StPause: begin
          cnt      <= '0;
          slowClkQ <= 1'b0;
          if (bus.run) begin
            state    <= StRun;
            starting <= 1'b1;
          end else if (stepRise) begin
            state    <= StStep;
            starting <= 1'b1;
          end
        end
        StRun, StStep: begin
          if (starting) begin
            starting <= 1'b0;
            cnt      <= '0;
            slowClkQ <= 1'b1;
            tickEnQ  <= 1'b1;
          end else if (wrap) begin
            cnt <= '0;
            if (slowClkQ) begin
              slowClkQ <= 1'b0;
            end else if ((state == StRun) && bus.run) begin
              slowClkQ <= 1'b1;
              tickEnQ  <= 1'b1;
            end else begin
              state <= StPause;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= StPause;
          starting <= 1'b0;
        end
      endcase
    end
  end

  assign bus.slowClk = slowClkQ;
  assign bus.tickEn  = tickEnQ;
  assign bus.rateAck = rateAckQ;
  assign bus.curRate = curRateQ;
  assign bus.busy    = (state != StPause);

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Scoreboard bench: stimulus queues expected tick/fall/ack cycles, a monitor pops and compares.
module tb_clk_enable_scheduler;

  logic inClk = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   vectors = 0;
  int   miscompares = 0;

  int tickQ[$];
  int fallQ[$];
  int ackCycQ[$];
  int ackRateQ[$];

  clk_enable_scheduler_if bus ();

  clk_enable_scheduler #(
    .CNT_W      (27),
    .RATE0      (3),
    .RATE1      (5),
    .RATE2      (8),
    .RATE3      (2),
    .RESET_RATE (0)
  ) dut (
    .inClk (inClk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 inClk = ~inClk;

  always @(posedge inClk) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge inClk);
  endtask

  task automatic pulseLoad(input int sel);
    bus.rateSel  = 2'(sel);
    bus.rateLoad = 1'b1;
    @(negedge inClk);
    bus.rateLoad = 1'b0;
  endtask

  // Monitor: compares every DUT event against the front of its queue.
  initial begin : monitor
    logic prevSlow;
    int   e;
    int   r;
    prevSlow = 1'b0;
    forever begin
      @(negedge inClk);
      if (reset) begin
        prevSlow = 1'b0;
      end else begin
        if (bus.tickEn) begin
          if (tickQ.size() == 0) begin
            chk("unexpected tickEn", cyc, -1);
          end else begin
            e = tickQ.pop_front();
            chk("tickEn cycle", cyc, e);
            chk("slowClk at tick", int'(bus.slowClk), 1);
          end
        end
        if (prevSlow && !bus.slowClk) begin
          if (fallQ.size() == 0) begin
            chk("unexpected slowClk fall", cyc, -1);
          end else begin
            e = fallQ.pop_front();
            chk("slowClk fall cycle", cyc, e);
          end
        end
        if (bus.rateAck) begin
          if (ackCycQ.size() == 0) begin
            chk("unexpected rateAck", cyc, -1);
          end else begin
            e = ackCycQ.pop_front();
            r = ackRateQ.pop_front();
            chk("rateAck cycle", cyc, e);
            chk("curRate at ack", int'(bus.curRate), r);
          end
        end
        prevSlow = bus.slowClk;
      end
    end
  end

  initial begin : stimulus
    int c;
    bus.run      = 1'b0;
    bus.stepReq  = 1'b0;
    bus.rateSel  = 2'd0;
    bus.rateLoad = 1'b0;

    repeat (3) @(negedge inClk);
    chk("reset slowClk", int'(bus.slowClk), 0);
    chk("reset tickEn", int'(bus.tickEn), 0);
    chk("reset rateAck", int'(bus.rateAck), 0);
    chk("reset curRate", int'(bus.curRate), 0);
    chk("reset busy", int'(bus.busy), 0);
    reset = 1'b0;
    repeat (2) @(negedge inClk);

    // Free run at rate 0 (3/3), then stop in the high phase of the third period.
    c = cyc;
    tickQ.push_back(c + 2);  fallQ.push_back(c + 5);
    tickQ.push_back(c + 8);  fallQ.push_back(c + 11);
    tickQ.push_back(c + 14); fallQ.push_back(c + 17);
    bus.run = 1'b1;
    waitUntil(c + 3);
    chk("run busy", int'(bus.busy), 1);
    chk("run slowClk high", int'(bus.slowClk), 1);
    waitUntil(c + 15);
    bus.run = 1'b0;
    waitUntil(c + 18);
    chk("draining busy", int'(bus.busy), 1);
    waitUntil(c + 30);
    chk("paused busy", int'(bus.busy), 0);
    chk("paused slowClk", int'(bus.slowClk), 0);

    // Rate change while running: 0 -> 1 at first boundary, then 1 then 2 before the next.
    c = cyc;
    tickQ.push_back(c + 2);  fallQ.push_back(c + 5);
    tickQ.push_back(c + 8);  fallQ.push_back(c + 13);
    tickQ.push_back(c + 18); fallQ.push_back(c + 23);
    tickQ.push_back(c + 28); fallQ.push_back(c + 36);
    ackCycQ.push_back(c + 8);  ackRateQ.push_back(1);
    ackCycQ.push_back(c + 28); ackRateQ.push_back(2);
    bus.run = 1'b1;
    waitUntil(c + 3);
    pulseLoad(1);
    waitUntil(c + 19);
    pulseLoad(1);
    waitUntil(c + 21);
    pulseLoad(2);
    waitUntil(c + 29);
    bus.run = 1'b0;
    waitUntil(c + 50);
    chk("after rate run busy", int'(bus.busy), 0);
    chk("after rate run curRate", int'(bus.curRate), 2);

    // Back to rate 0 from PAUSE: ack two cycles after the strobe is driven.
    c = cyc;
    ackCycQ.push_back(c + 2); ackRateQ.push_back(0);
    pulseLoad(0);
    waitUntil(c + 5);

    // Single step with stepReq held for 20 cycles.
    c = cyc;
    tickQ.push_back(c + 2); fallQ.push_back(c + 5);
    bus.stepReq = 1'b1;
    waitUntil(c + 3);
    chk("step busy", int'(bus.busy), 1);
    waitUntil(c + 10);
    chk("step done busy", int'(bus.busy), 0);
    waitUntil(c + 20);
    bus.stepReq = 1'b0;
    waitUntil(c + 23);

    // A step edge while running changes nothing.
    c = cyc;
    tickQ.push_back(c + 2); fallQ.push_back(c + 5);
    tickQ.push_back(c + 8); fallQ.push_back(c + 11);
    bus.run = 1'b1;
    waitUntil(c + 3);
    bus.stepReq = 1'b1;
    waitUntil(c + 5);
    bus.stepReq = 1'b0;
    waitUntil(c + 9);
    bus.run = 1'b0;
    waitUntil(c + 20);
    chk("run+step busy", int'(bus.busy), 0);

    // Rate 3 loaded in PAUSE, then a 2/2 period.
    c = cyc;
    ackCycQ.push_back(c + 2); ackRateQ.push_back(3);
    tickQ.push_back(c + 6);  fallQ.push_back(c + 8);
    tickQ.push_back(c + 10); fallQ.push_back(c + 12);
    pulseLoad(3);
    waitUntil(c + 4);
    bus.run = 1'b1;
    waitUntil(c + 11);
    bus.run = 1'b0;
    waitUntil(c + 20);
    chk("rate3 curRate", int'(bus.curRate), 3);
    chk("rate3 busy", int'(bus.busy), 0);

    // Reset in the high phase with a pending rate: everything cleared, no ack afterwards.
    c = cyc;
    tickQ.push_back(c + 2);
    bus.run = 1'b1;
    waitUntil(c + 2);
    pulseLoad(1);
    #2 reset = 1'b1;
    #1;
    chk("async reset slowClk", int'(bus.slowClk), 0);
    chk("async reset tickEn", int'(bus.tickEn), 0);
    chk("async reset curRate", int'(bus.curRate), 0);
    chk("async reset busy", int'(bus.busy), 0);
    bus.run = 1'b0;
    repeat (3) @(negedge inClk);
    reset = 1'b0;
    repeat (10) @(negedge inClk);
    chk("post reset curRate", int'(bus.curRate), 0);
    chk("post reset rateAck", int'(bus.rateAck), 0);
    chk("post reset busy", int'(bus.busy), 0);

    while (tickQ.size() > 0) chk("missing tickEn", -1, tickQ.pop_front());
    while (fallQ.size() > 0) chk("missing slowClk fall", -1, fallQ.pop_front());
    while (ackCycQ.size() > 0) begin
      chk("missing rateAck", -1, ackCycQ.pop_front());
      void'(ackRateQ.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_enable_scheduler.md
Name: clk_enable_scheduler

Overview:
- Run/pause/single-step controller for the design's slow clock.
- Replaces the fixed divide with a selectable rate table and produces two outputs: a 50%-duty slowClk and a one-cycle tickEn qualifier in the inClk domain.
- Sits between the Nexys3 100 MHz oscillator/board buttons and the sequence-detector logic.
- Rate changes are applied only at period boundaries, so slowClk never glitches.

Parameters:
- CNT_W, 27, half-period counter width.
- RATE0, 100_000, half-period in inClk cycles for rateSel=0 (500 Hz).
- RATE1, 1_000_000, half-period for rateSel=1 (50 Hz).
- RATE2, 10_000_000, half-period for rateSel=2 (5 Hz).
- RATE3, 50_000_000, half-period for rateSel=3 (1 Hz).
- RESET_RATE, 0, rate index loaded at reset.

Ports:
- inClk  in  1  system clock, 100 MHz.
- reset  in  1  reset; asynchronous, active-high; clears all state.
- run  in  1  level, synchronous (already debounced); 1 = free-run.
- stepReq  in  1  level, synchronous; a rising edge requests one period while paused.
- rateSel  in  2  requested rate index.
- rateLoad  in  1  one-cycle strobe that captures rateSel.
- rateAck  out  1  one-cycle pulse when the pending rate becomes active.
- curRate  out  2  active rate index.
- slowClk  out  1  divided clock, 50% duty.
- tickEn  out  1  one-cycle pulse, coincident with the cycle slowClk becomes 1.
- busy  out  1  1 when state != PAUSE.

Behaviour:
- Reset values: state=PAUSE, cnt=0, slowClk=0, tickEn=0, rateAck=0, curRate=RESET_RATE, pendValid=0, stepReq edge register=0.
- States and transitions:
  - PAUSE: cnt held at 0, slowClk held at 0.
  - PAUSE -> RUN when run=1.
  - PAUSE -> STEP on a stepReq rising edge with run=0.
  - On entering RUN or STEP: the next cycle has slowClk=1, tickEn=1, cnt=0.
- Counting (RUN and STEP): cnt increments every cycle. When cnt = HP-1 ("wrap"), cnt<=0, where HP = RATE[curRate].
  - Wrap with slowClk=1: slowClk<=0.
  - Wrap with slowClk=0 is the period boundary:
    - RUN with run=1: slowClk<=1, tickEn<=1.
    - RUN with run=0: go to PAUSE.
    - STEP: always go to PAUSE.
- Pause requests: run is sampled only at the period boundary. Deasserting run mid-period always completes the current full period.
- Step request is ignored in RUN or STEP (the edge is discarded, not queued). stepReq held high causes one step only.
- Rate change:
  - rateLoad sets pendRate<=rateSel and pendValid<=1.
  - A later rateLoad before the rate is applied overwrites pendRate; only one rateAck is produced.
  - The pending rate is applied at the period boundary, or in PAUSE on the cycle after it is captured: curRate<=pendRate, pendValid<=0, rateAck=1 for one cycle.
  - A rateLoad in the same cycle as a boundary is applied at the next boundary, not the current one.
  - The new HP takes effect from the first half-period after application.
- Rate 0 is not used as a period. HP must be >= 2; the synthesis check rejects RATE* < 2.
- Width: cnt is CNT_W bits unsigned. The default RATE3 fits 27 bits and the counter never exceeds HP-1.
- Latency:
  - run 0->1 in PAUSE to the first tickEn: 2 cycles.
  - rateLoad in PAUSE to rateAck: 2 cycles.
- Reset asserted mid-operation forces the reset values immediately (asynchronously). A pending rate is lost.

Decomposition:
- Shared package (clk_sched_pkg):
  - state encodings PAUSE/RUN/STEP;
  - RATE_SEL_W=2;
  - default RATE0..RATE3 constants;
  - CNT_W.
- Sub-module rise_detect: one-flop rising-edge detector on stepReq, clocked by inClk and cleared by reset.
- Everything else lives in the top module.

Test Plan:
- Test-plan parameters for simulation: RATE0=3, RATE1=5, RATE2=8, RATE3=2.
- Reset then run=1: tickEn pulses every 6 cycles; slowClk is high for 3 cycles and low for 3; busy=1.
- Mid-high-phase run=0: the current period completes (low phase of 3 cycles), then state=PAUSE, slowClk=0, busy=0; no further tickEn.
- Rate change while running: rateLoad with rateSel=1 during the high phase of a RATE0 period. rateAck pulses at the next boundary and curRate=1. The following period is high 5 cycles and low 5. Two rateLoads before the boundary (1 then 2) give one rateAck and curRate=2.
- Single step: PAUSE, stepReq held high for 20 cycles gives exactly one tickEn and one period (3 high, 3 low), then PAUSE. A stepReq edge while run=1 has no extra effect.
- rateLoad in PAUSE with rateSel=3: rateAck is asserted 2 cycles later and curRate=3. Then run=1 gives a period of 2 high, 2 low.
- Reset asserted mid-high-phase with a pending rate: slowClk=0, tickEn=0, cnt=0, curRate=RESET_RATE, with no rateAck after release.
